// File: rtl/max_pkg.sv
// Shared definitions for the max/compare partitions: default operand sizing
// and the packet-sequencer state encoding.
package max_pkg;

    localparam int MAX_W = 8;
    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/max_cmp.sv
// Unsigned magnitude comparator, kept as its own partition so an approximate
// implementation can be dropped in without touching the sequencer.
module max_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         a_gt_b
);

    assign a_gt_b = (a > b);

endmodule

// File: rtl/max_stream_seq.sv
// Packet sequencer: streams up to N words through one shared comparator and
// reports max, first-occurrence index, word count and forced-close flag.
module max_stream_seq
    import max_pkg::*;
#(
    parameter int W  = MAX_W,
    parameter int N  = MAX_N,
    parameter int IW = $clog2(N),
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_max,
    output logic [IW-1:0] out_idx,
    output logic [CW-1:0] out_cnt,
    output logic          out_trunc
);

    state_t        r_state;
    logic [W-1:0]  r_max;
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_trunc;
    logic          r_in_ready;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_gt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_at_cap;

    assign w_accept  = in_valid && r_in_ready;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_at_cap  = (w_cnt_inc == CW'(N));

    max_cmp #(.W(W)) u_cmp (
        .a      (in_data),
        .b      (r_max),
        .a_gt_b (w_gt)
    );

    // NOTE: in_ready/out_valid are registered alongside the state so that
    // neither handshake has a combinational path from the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_max       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_max <= in_data;
                        r_idx <= '0;
                        r_cnt <= CW'(1);
                        if (in_last) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        if (w_gt) begin
                            r_max <= in_data;
                            r_idx <= IW'(r_cnt);
                        end
                        r_cnt <= w_cnt_inc;
                        // The Nth word closes the packet even without in_last.
                        if (in_last || w_at_cap) begin
                            r_state     <= DONE;
                            r_trunc     <= !in_last;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_trunc     <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_max   = r_max;
    assign out_idx   = r_idx;
    assign out_cnt   = r_cnt;
    assign out_trunc = r_trunc;

endmodule

// File: tb/tb_max_stream_seq.sv
// Self-checking bench for max_stream_seq (N=4): directed vector table,
// hand-written corner sequences, then a random scoreboard run.
module tb_max_stream_seq;

    localparam int W    = 8;
    localparam int N    = 4;
    localparam int IW   = $clog2(N);
    localparam int CW   = $clog2(N + 1);
    localparam int NPKT = 3000;

    typedef struct packed {
        logic [W-1:0]  mx;
        logic [IW-1:0] idx;
        logic [CW-1:0] cnt;
        logic          tr;
    } res_t;

    typedef struct {
        int                  len;
        logic [3:0][W-1:0]   d;
        int                  last_at;
        res_t                exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_max;
    logic [IW-1:0] out_idx;
    logic [CW-1:0] out_cnt;
    logic          out_trunc;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t sb_q[$];
    bit   close_pending = 1'b0;
    bit   drv_done      = 1'b0;

    logic [W-1:0] m_max;
    int           m_idx;
    int           m_cnt = 0;

    always #5 clk = ~clk;

    max_stream_seq #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_cnt   (out_cnt),
        .out_trunc (out_trunc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t mkres(input logic [W-1:0] m, input int i, input int c, input bit t);
        res_t r;
        r.mx  = m;
        r.idx = IW'(i);
        r.cnt = CW'(c);
        r.tr  = t;
        return r;
    endfunction

    function automatic vec_t mk(input int len, input logic [W-1:0] w0, input logic [W-1:0] w1,
                                input logic [W-1:0] w2, input logic [W-1:0] w3,
                                input int last_at, input res_t e);
        vec_t v;
        v.len     = len;
        v.d[0]    = w0;
        v.d[1]    = w1;
        v.d[2]    = w2;
        v.d[3]    = w3;
        v.last_at = last_at;
        v.exp     = e;
        return v;
    endfunction

    function automatic res_t cur_out();
        return {out_max, out_idx, out_cnt, out_trunc};
    endfunction

    // Presents a word and returns at the negedge before the edge that accepts it.
    task automatic send_word(input logic [W-1:0] d, input logic l, input int gaps);
        int budget;
        repeat (gaps) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_hs_valid_low", 32'(out_valid), 32'd0);
    endtask

    task automatic model_accept(input logic [W-1:0] d, input logic l);
        if (m_cnt == 0) begin
            m_max = d;
            m_idx = 0;
            m_cnt = 1;
        end else begin
            if (d > m_max) begin
                m_max = d;
                m_idx = m_cnt;
            end
            m_cnt++;
        end
        if (l || m_cnt == N) begin
            sb_q.push_back(mkres(m_max, m_idx, m_cnt, !l));
            m_cnt         = 0;
            close_pending = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'(cur_out()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        vecs[0] = mk(4, 8'h03, 8'h09, 8'h09, 8'h02, 3,  mkres(8'h09, 1, 4, 1'b0));
        vecs[1] = mk(1, 8'h2A, 8'h00, 8'h00, 8'h00, 0,  mkres(8'h2A, 0, 1, 1'b0));
        vecs[2] = mk(3, 8'h06, 8'h06, 8'h06, 8'h00, 2,  mkres(8'h06, 0, 3, 1'b0));
        vecs[3] = mk(2, 8'h00, 8'h00, 8'h00, 8'h00, 1,  mkres(8'h00, 0, 2, 1'b0));
        vecs[4] = mk(2, 8'h7F, 8'h80, 8'h00, 8'h00, 1,  mkres(8'h80, 1, 2, 1'b0));
        vecs[5] = mk(4, 8'h01, 8'h02, 8'h03, 8'h04, -1, mkres(8'h04, 3, 4, 1'b1));
        vecs[6] = mk(4, 8'h00, 8'h80, 8'h00, 8'hFF, 3,  mkres(8'hFF, 3, 4, 1'b0));

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < vecs[v].len; i++)
                send_word(vecs[v].d[i], (i == vecs[v].last_at), $urandom_range(0, 2));
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_latency", v), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_result", v), 32'(cur_out()), 32'(vecs[v].exp));
            take_result();
        end

        // Truncation: the held 5th word must wait for the handshake.
        send_word(8'h05, 1'b0, 0);
        send_word(8'h01, 1'b0, 0);
        send_word(8'h07, 1'b0, 0);
        send_word(8'h07, 1'b0, 0);
        @(negedge clk);
        in_data = 8'h08;
        check("trunc_blocked", 32'({out_valid, in_ready}), 32'b10);
        check("trunc_result", 32'(cur_out()), 32'(mkres(8'h07, 2, 4, 1'b1)));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("trunc_reopen", 32'({out_valid, in_ready}), 32'b01);
        in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("trunc_next_pkt", 32'({out_valid, cur_out()}), 32'({1'b1, mkres(8'h08, 0, 1, 1'b0)}));
        take_result();

        // Backpressure: result held for 10 cycles.
        send_word(8'hFF, 1'b1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_hold%0d", c), 32'({out_valid, in_ready, cur_out()}),
                  32'({1'b1, 1'b0, mkres(8'hFF, 0, 1, 1'b0)}));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release", 32'({out_valid, in_ready}), 32'b01);

        // Reset in the middle of a packet.
        send_word(8'h0A, 1'b0, 0);
        send_word(8'h14, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_async", 32'({out_valid, in_ready}), 32'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_recover", 32'({out_valid, in_ready}), 32'b01);
        send_word(8'h04, 1'b1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst_new_pkt", 32'({out_valid, cur_out()}), 32'({1'b1, mkres(8'h04, 0, 1, 1'b0)}));
        take_result();

        // Random packets against the reference model.
        fork
            begin : driver
                int           p = 0;
                int           i = 0;
                int           len;
                bit           have = 1'b0;
                logic [W-1:0] cur;
                logic         cur_last;
                len = $urandom_range(1, N + 2);
                while (p < NPKT) begin
                    @(negedge clk);
                    if (close_pending) begin
                        check("rnd_latency", 32'(out_valid), 32'd1);
                        close_pending = 1'b0;
                    end
                    if (!have) begin
                        if ($urandom_range(0, 3) == 0) begin
                            in_valid = 1'b0;
                            continue;
                        end
                        cur      = $urandom_range(0, 1) ? W'($urandom_range(0, 7)) : W'($urandom_range(0, 255));
                        cur_last = (i == len - 1);
                        have     = 1'b1;
                    end
                    in_valid = 1'b1;
                    in_data  = cur;
                    in_last  = cur_last;
                    if (in_ready) begin
                        model_accept(cur, cur_last);
                        have = 1'b0;
                        i++;
                        if (i == len) begin
                            p++;
                            i   = 0;
                            len = $urandom_range(1, N + 2);
                        end
                    end
                end
                @(negedge clk);
                in_valid = 1'b0;
                if (close_pending) begin
                    check("rnd_latency", 32'(out_valid), 32'd1);
                    close_pending = 1'b0;
                end
                drv_done = 1'b1;
            end
            begin : monitor
                res_t prev;
                res_t now;
                bit   prev_stall = 1'b0;
                while (!(drv_done && sb_q.size() == 0 && !out_valid)) begin
                    @(negedge clk);
                    now = cur_out();
                    if (prev_stall) begin
                        check("rnd_valid_hold", 32'(out_valid), 32'd1);
                        check("rnd_out_stable", 32'(now), 32'(prev));
                    end
                    if (out_valid) begin
                        check("rnd_in_ready_low", 32'(in_ready), 32'd0);
                        out_ready = 1'($urandom_range(0, 1));
                        if (out_ready) begin
                            prev_stall = 1'b0;
                            if (sb_q.size() == 0) begin
                                check("rnd_unexpected_out", 32'd1, 32'd0);
                            end else begin
                                check("rnd_result", 32'(now), 32'(sb_q.pop_front()));
                            end
                        end else begin
                            prev_stall = 1'b1;
                            prev       = now;
                        end
                    end else begin
                        prev_stall = 1'b0;
                        out_ready  = 1'($urandom_range(0, 1));
                    end
                end
                out_ready = 1'b0;
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
